// File: rtl/activation_lut_writer_pkg.sv
// Shared constants and types for the loadable activation table and its
// readers: entry width, address width, table depth and the loader FSM states.
package activation_lut_writer_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef logic signed [DATA_W-1:0] entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/activation_lut_writer_if.sv
// Valid/ready stream that carries table entries from the parameter-load path
// into the loader.
interface activation_lut_writer_if;
  import activation_lut_writer_pkg::*;

  logic   wr_valid;
  entry_t wr_data;
  logic   wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/activation_lut_regfile.sv
// DEPTH x DATA_W register file: one synchronous write port and two
// combinational read ports, cleared by reset.
module activation_lut_regfile
  import activation_lut_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  entry_t            wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output entry_t            rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output entry_t            rd_data_b
);

  entry_t mem [DEPTH];

  // NOTE: the table is flops, not a RAM macro, so it can be cleared in reset;
  // an aborted load must never leave stale entries readable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/activation_lut_writer.sv
// Loads 16 signed breakpoints over valid/ready into a register file and serves
// the base / next (clamped) pair for the activation interpolator.
module activation_lut_writer
  import activation_lut_writer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  activation_lut_writer_if.slave  wr,
  output logic                    busy,
  output logic                    load_done,
  output logic                    table_valid,
  input  logic [ADDR_W-1:0]       address,
  output entry_t                  base,
  output entry_t                  next__data
);

  state_e            state, state_next;
  logic [ADDR_W-1:0] wr_cnt, wr_cnt_next;
  logic              valid_q, valid_next;
  logic              accept;
  logic [ADDR_W-1:0] next_addr;
  entry_t            rd_base, rd_next;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    wr_cnt_next = wr_cnt;
    valid_next  = valid_q;
    wr.wr_ready = 1'b0;
    busy        = 1'b0;
    load_done   = 1'b0;
    accept      = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_next  = LOAD;
          wr_cnt_next = '0;
          valid_next  = 1'b0;
        end
      end
      LOAD: begin
        wr.wr_ready = 1'b1;
        busy        = 1'b1;
        if (wr.wr_valid) begin
          accept      = 1'b1;
          wr_cnt_next = wr_cnt + 1'b1;
          // table_valid rises together with load_done, one cycle after the last accept
          if (wr_cnt == LAST_ADDR) begin
            state_next = DONE;
            valid_next = 1'b1;
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples the values
  // computed in the same cycle, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      wr_cnt  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      wr_cnt  <= wr_cnt_next;
      valid_q <= valid_next;
    end
  end

  assign table_valid = valid_q;

  // Clamp at the top entry instead of wrapping to entry 0.
  assign next_addr = (address == LAST_ADDR) ? address : address + 1'b1;

  activation_lut_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (accept),
    .wr_addr   (wr_cnt),
    .wr_data   (wr.wr_data),
    .rd_addr_a (address),
    .rd_data_a (rd_base),
    .rd_addr_b (next_addr),
    .rd_data_b (rd_next)
  );

  assign base       = valid_q ? rd_base : '0;
  assign next__data = valid_q ? rd_next : '0;

endmodule
